// File: rtl/stage_buf.sv
// stage_buf: one pipeline stage with a valid/ready handshake on both sides.
// The output payload always comes from a register. A saturating counter
// counts the cycles in which upstream is blocked.
// Build option STAGE_BUF_SKID_EN: adds a second skid entry, so that in_ready
// is a registered signal with no combinational path from out_ready.
// Without the option the stage is a single register, and in_ready is
// combinational.
module stage_buf #(
    parameter int WIDTH       = 64,
    parameter int RST_PAYLOAD = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [CNT_W-1:0] stall_cnt,
    input  logic             cnt_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    logic             in_ready_s;
    logic             in_xfer_s;
    logic             out_xfer_s;
    logic             valid_r;
    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] data_nxt_s;
    logic [CNT_W-1:0] cnt_r;

    assign in_xfer_s  = in_valid & in_ready_s;
    assign out_xfer_s = valid_r & out_ready;

`ifdef STAGE_BUF_SKID_EN
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t           state_r;
    logic             rdy_r;
    logic [WIDTH-1:0] skid_r;
    logic [WIDTH-1:0] skid_nxt_s;

    // Gate the registered ready with reset so that it reads 0 while reset is held.
    // It resets to 1, so the first edge after reset is released can accept data.
    assign in_ready_s = rdy_r & rst;

    // Occupancy state machine: drives the registered valid and ready flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_EMPTY;
            valid_r <= 1'b0;
            rdy_r   <= 1'b1;
        end else if (flush) begin
            state_r <= ST_EMPTY;
            valid_r <= 1'b0;
            rdy_r   <= 1'b1;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_xfer_s) begin
                        state_r <= ST_FULL;
                        valid_r <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (in_xfer_s && !out_xfer_s) begin
                        state_r <= ST_SKID;
                        rdy_r   <= 1'b0;
                    end else if (!in_xfer_s && out_xfer_s) begin
                        state_r <= ST_EMPTY;
                        valid_r <= 1'b0;
                    end
                end
                ST_SKID: begin
                    if (out_xfer_s) begin
                        state_r <= ST_FULL;
                        rdy_r   <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                    valid_r <= 1'b0;
                    rdy_r   <= 1'b1;
                end
            endcase
        end
    end

    // Next payload for the output and skid registers. It follows the same
    // transitions as the state machine.
    always_comb begin
        data_nxt_s = data_r;
        skid_nxt_s = skid_r;
        if (flush) begin
            if (RST_PAYLOAD != 0) begin
                data_nxt_s = {WIDTH{1'b0}};
                skid_nxt_s = {WIDTH{1'b0}};
            end else begin
                data_nxt_s = data_r;
                skid_nxt_s = skid_r;
            end
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_xfer_s) data_nxt_s = in_data;
                    else           data_nxt_s = data_r;
                end
                ST_FULL: begin
                    if (in_xfer_s && out_xfer_s) data_nxt_s = in_data;
                    else if (in_xfer_s)          skid_nxt_s = in_data;
                    else                         data_nxt_s = data_r;
                end
                ST_SKID: begin
                    if (out_xfer_s) data_nxt_s = skid_r;
                    else            data_nxt_s = data_r;
                end
                default: begin
                    data_nxt_s = data_r;
                    skid_nxt_s = skid_r;
                end
            endcase
        end
    end

    generate
        if (RST_PAYLOAD != 0) begin : g_skid_rst
            // Skid payload register, cleared by reset.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) skid_r <= {WIDTH{1'b0}};
                else      skid_r <= skid_nxt_s;
            end
        end else begin : g_skid_norst
            // Skid payload register without reset. It is only read when the state is SKID.
            always_ff @(posedge clk) begin
                skid_r <= skid_nxt_s;
            end
        end
    endgenerate
`else
    // A new payload fits when the register is empty or is being drained this cycle.
    assign in_ready_s = rst & (~valid_r | out_ready);

    // Valid flag of the single output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            valid_r <= 1'b0;
        else if (flush)      valid_r <= 1'b0;
        else if (in_xfer_s)  valid_r <= 1'b1;
        else if (out_xfer_s) valid_r <= 1'b0;
    end

    // Next payload: flush clears it or keeps it (set by RST_PAYLOAD); otherwise it loads on accept.
    always_comb begin
        data_nxt_s = data_r;
        if (flush) begin
            if (RST_PAYLOAD != 0) data_nxt_s = {WIDTH{1'b0}};
            else                  data_nxt_s = data_r;
        end else if (in_xfer_s) begin
            data_nxt_s = in_data;
        end else begin
            data_nxt_s = data_r;
        end
    end
`endif

    generate
        if (RST_PAYLOAD != 0) begin : g_data_rst
            // Output payload register, cleared by reset.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) data_r <= {WIDTH{1'b0}};
                else      data_r <= data_nxt_s;
            end
        end else begin : g_data_norst
            // Output payload register without reset. out_valid qualifies it.
            always_ff @(posedge clk) begin
                data_r <= data_nxt_s;
            end
        end
    endgenerate

    // Blocked-upstream counter: saturates at its maximum, and clear beats increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (in_valid && !in_ready_s && !flush && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = valid_r;
    assign out_data  = data_r;
    assign stall_cnt = cnt_r;

endmodule

// File: tb/tb_stage_buf.sv
// Directed testbench for stage_buf (WIDTH=8, CNT_W=4).
// The main instance clears its payload on reset and flush; a second instance does not.
// Where STAGE_BUF_SKID_EN changes the expected value, both expectations are
// written out under the same macro.
module tb_stage_buf;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       flush;
    logic       cnt_clr;

    logic       in_ready,  in_ready_np;
    logic       out_valid, out_valid_np;
    logic [7:0] out_data,  out_data_np;
    logic [3:0] stall_cnt, stall_cnt_np;

    int errors = 0;
    int checks = 0;

    stage_buf #(.WIDTH(8), .RST_PAYLOAD(1), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .flush(flush), .stall_cnt(stall_cnt), .cnt_clr(cnt_clr)
    );

    stage_buf #(.WIDTH(8), .RST_PAYLOAD(0), .CNT_W(4)) dut_np (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_np),
        .in_data(in_data), .out_valid(out_valid_np), .out_ready(out_ready),
        .out_data(out_data_np), .flush(flush), .stall_cnt(stall_cnt_np), .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        out_ready = 1'b0; flush = 1'b0; cnt_clr = 1'b0;

        // Reset state before any clock edge
        #3;
        check("rst_valid", {7'd0, out_valid}, 8'd0);
        check("rst_data",  out_data, 8'h00);
        check("rst_cnt",   {4'd0, stall_cnt}, 8'd0);
        check("rst_ready", {7'd0, in_ready}, 8'd0);
        tick();
        tick();

        // Streaming 1..6, one per cycle, starting at the first edge after release
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            in_data = 8'(i);
            tick();
            check("stream_valid", {7'd0, out_valid}, 8'd1);
            check("stream_data",  out_data, 8'(i));
        end
        check("stream_ready", {7'd0, in_ready}, 8'd1);
        check("stream_cnt",   {4'd0, stall_cnt}, 8'd0);
        in_valid = 1'b0;
        tick();
        check("bubble_valid", {7'd0, out_valid}, 8'd0);

        // Backpressure: load A5, then offer A6 for 5 cycles with out_ready=0
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hA5;
        tick();
        check("bp_load", out_data, 8'hA5);
        in_data = 8'hA6;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_data",  out_data, 8'hA5);
            check("bp_hold_valid", {7'd0, out_valid}, 8'd1);
        end
        check("bp_ready", {7'd0, in_ready}, 8'd0);
`ifdef STAGE_BUF_SKID_EN
        check("bp_cnt", {4'd0, stall_cnt}, 8'd4);
`else
        check("bp_cnt", {4'd0, stall_cnt}, 8'd5);
`endif
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
`ifdef STAGE_BUF_SKID_EN
        check("bp_rel_valid", {7'd0, out_valid}, 8'd1);
        check("bp_rel_data",  out_data, 8'hA6);
`else
        check("bp_rel_valid", {7'd0, out_valid}, 8'd0);
`endif
        tick();
        check("bp_drained", {7'd0, out_valid}, 8'd0);
        cnt_clr = 1'b1;
        tick();
        check("clr_cnt", {4'd0, stall_cnt}, 8'd0);
        cnt_clr = 1'b0;

        // Flush arriving in the same cycle as an input and an output transfer
        in_valid = 1'b1; in_data = 8'h33; out_ready = 1'b1;
        tick();
        check("fl_pre_data", out_data, 8'h33);
        flush = 1'b1; in_data = 8'h44;
        tick();
        check("fl_valid",    {7'd0, out_valid}, 8'd0);
        check("fl_data",     out_data, 8'h00);
        check("fl_np_valid", {7'd0, out_valid_np}, 8'd0);
        check("fl_np_data",  out_data_np, 8'h33);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        check("fl_discard", {7'd0, out_valid}, 8'd0);

        // Saturation: block upstream for 20+ cycles, then clear while still blocked
        in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) tick();
        check("sat_cnt",    {4'd0, stall_cnt}, 8'd15);
        check("sat_np_cnt", {4'd0, stall_cnt_np}, 8'd15);
        cnt_clr = 1'b1;
        tick();
        check("sat_clr", {4'd0, stall_cnt}, 8'd0);
        cnt_clr = 1'b0;
        tick();
        check("sat_restart", {4'd0, stall_cnt}, 8'd1);

        // Async reset between edges while the stage is full (SKID in skid builds)
        #2;
        rst = 1'b0;
        #1;
        check("ar_valid",    {7'd0, out_valid}, 8'd0);
        check("ar_cnt",      {4'd0, stall_cnt}, 8'd0);
        check("ar_ready",    {7'd0, in_ready}, 8'd0);
        check("ar_data",     out_data, 8'h00);
        check("ar_np_valid", {7'd0, out_valid_np}, 8'd0);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h01; out_ready = 1'b1;
        tick();
        check("ar_post_valid", {7'd0, out_valid}, 8'd1);
        check("ar_post_data",  out_data, 8'h01);
        in_valid = 1'b0;
        tick();
        check("ar_post_drain", {7'd0, out_valid}, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
